// File: rtl/nmr_acq_capture.sv
`default_nettype none
// ============================================================================
// Module      : nmr_acq_capture
// Description : Receive-side capture for the NMR pulse program sequencer.
//               Samples ADC_DATA once per ADC_CLK rising edge while the
//               sequencer holds ACQ_WND inside an active sequence (FSMSTAT),
//               packs two samples per 32-bit word (earlier sample in the low
//               half), buffers words in a show-ahead FIFO and presents them on
//               a valid/ready stream. Keeps per-sequence echo/sample counters
//               and a sticky overflow flag.
// Ports       : CLK, RESET_N        - clock, async active-low reset
//               FSMSTAT, ACQ_WND    - sequence-active flag, acquisition window
//               ADC_CLK, ADC_DATA   - ADC sample clock (CLK domain) and data
//               OUT_DATA/VALID/READY- output word stream (FIFO head)
//               ECHO_CNT, SAMPLE_CNT- windows / samples of current-last sequence
//               OVERFLOW            - sticky word-dropped flag
//               BUSY, DONE          - sequence in progress, completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module nmr_acq_capture #(
    parameter int DATABUS_WIDTH   = 32,
    parameter int ADC_WIDTH       = 14,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     FSMSTAT,
    input  logic                     ACQ_WND,
    input  logic                     ADC_CLK,
    input  logic [ADC_WIDTH-1:0]     ADC_DATA,
    output logic [DATABUS_WIDTH-1:0] OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [CNT_WIDTH-1:0]     ECHO_CNT,
    output logic [CNT_WIDTH-1:0]     SAMPLE_CNT,
    output logic                     OVERFLOW,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W      = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_GAP     = 3'd3,
        ST_FLUSH   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic                   adc_clk_q;
    logic                   fsmstat_q;
    logic [CNT_WIDTH-1:0]   echo_cnt_q,   echo_cnt_d;
    logic [CNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
    logic                   overflow_q,   overflow_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [15:0]            pend_data_q,  pend_data_d;
    logic [PTR_W-1:0]       wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,     rd_ptr_d;
    logic [DATABUS_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                     strobe;
    logic                     fsm_rise;
    logic                     clear_stats;
    logic                     push;
    logic [DATABUS_WIDTH-1:0] push_word;
    logic                     push_ok;
    logic                     pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [15:0]              sample16;

    // ACQ_WND and FSMSTAT-low are acted on as levels; only the ADC clock and
    // the sequence start need edge detection.
    assign strobe   = ADC_CLK & ~adc_clk_q;
    assign fsm_rise = FSMSTAT & ~fsmstat_q;
    assign sample16 = 16'(ADC_DATA);

    // ------------------------------------------------------------------
    // Sequencing FSM, counters and packer
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        echo_cnt_d   = echo_cnt_q;
        sample_cnt_d = sample_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        clear_stats  = 1'b0;
        push         = 1'b0;
        push_word    = '0;

        case (state_q)
            ST_IDLE: begin
                if (fsm_rise) begin
                    state_d      = ST_ARMED;
                    echo_cnt_d   = '0;
                    sample_cnt_d = '0;
                    clear_stats  = 1'b1;
                end
            end

            ST_ARMED: begin
                if (!FSMSTAT) begin
                    state_d = ST_FLUSH;
                end else if (ACQ_WND) begin
                    state_d    = ST_CAPTURE;
                    echo_cnt_d = echo_cnt_q + CNT_WIDTH'(1);
                end
            end

            ST_CAPTURE: begin
                // A strobe on the same edge that closes the window is dropped;
                // any pending half-word is padded out in the following state.
                if (!FSMSTAT) begin
                    state_d = ST_FLUSH;
                end else if (!ACQ_WND) begin
                    state_d = ST_GAP;
                end else if (strobe) begin
                    if (sample_cnt_q != {CNT_WIDTH{1'b1}}) begin
                        sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
                    end
                    if (pend_valid_q) begin
                        push         = 1'b1;
                        push_word    = DATABUS_WIDTH'({sample16, pend_data_q});
                        pend_valid_d = 1'b0;
                    end else begin
                        pend_data_d  = sample16;
                        pend_valid_d = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                // First GAP cycle flushes an odd sample so each echo starts
                // word-aligned.
                if (pend_valid_q) begin
                    push         = 1'b1;
                    push_word    = DATABUS_WIDTH'({16'h0000, pend_data_q});
                    pend_valid_d = 1'b0;
                end
                if (!FSMSTAT) begin
                    state_d = ST_FLUSH;
                end else if (ACQ_WND) begin
                    state_d    = ST_CAPTURE;
                    echo_cnt_d = echo_cnt_q + CNT_WIDTH'(1);
                end
            end

            ST_FLUSH: begin
                if (pend_valid_q) begin
                    push         = 1'b1;
                    push_word    = DATABUS_WIDTH'({16'h0000, pend_data_q});
                    pend_valid_d = 1'b0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d      = ST_IDLE;
                pend_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign pop        = ~fifo_empty & OUT_READY;
    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // take a word when the consumer is reading.
    assign push_ok    = push & (~fifo_full | pop);
    assign wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

    always_comb begin
        overflow_d = overflow_q;
        if (clear_stats) begin
            overflow_d = 1'b0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            adc_clk_q    <= 1'b0;
            fsmstat_q    <= 1'b0;
            echo_cnt_q   <= '0;
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            adc_clk_q    <= ADC_CLK;
            fsmstat_q    <= FSMSTAT;
            echo_cnt_q   <= echo_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            overflow_q   <= overflow_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= push_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head word is forced to zero when empty so reset/idle reads are clean.
    assign OUT_DATA   = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-2:0]];
    assign OUT_VALID  = ~fifo_empty;
    assign ECHO_CNT   = echo_cnt_q;
    assign SAMPLE_CNT = sample_cnt_q;
    assign OVERFLOW   = overflow_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = (state_q == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_nmr_acq_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmr_acq_capture
// Description : Self-checking bench for nmr_acq_capture. Single-window
//               sequences come from a record table; latency, overflow,
//               multi-echo, idle-window and reset cases are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nmr_acq_capture;

    localparam int DW  = 32;
    localparam int AW  = 14;
    localparam int FL2 = 4;
    localparam int CW  = 16;

    logic          CLK       = 1'b0;
    logic          RESET_N   = 1'b0;
    logic          FSMSTAT   = 1'b0;
    logic          ACQ_WND   = 1'b0;
    logic          ADC_CLK   = 1'b0;
    logic [AW-1:0] ADC_DATA  = '0;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic [CW-1:0] ECHO_CNT;
    logic [CW-1:0] SAMPLE_CNT;
    logic          OVERFLOW;
    logic          BUSY;
    logic          DONE;

    nmr_acq_capture #(
        .DATABUS_WIDTH  (DW),
        .ADC_WIDTH      (AW),
        .FIFO_DEPTH_LOG2(FL2),
        .CNT_WIDTH      (CW)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .FSMSTAT   (FSMSTAT),
        .ACQ_WND   (ACQ_WND),
        .ADC_CLK   (ADC_CLK),
        .ADC_DATA  (ADC_DATA),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ECHO_CNT  (ECHO_CNT),
        .SAMPLE_CNT(SAMPLE_CNT),
        .OVERFLOW  (OVERFLOW),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] got [$];
    int          done_cnt = 0;

    // Words are recorded on the falling edge where a handshake is set up;
    // the pop itself happens on the following rising edge.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (OUT_VALID && OUT_READY) got.push_back(OUT_DATA);
            if (DONE) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One ADC period (CLK/4); the strobe lands on the first rising edge.
    task automatic adc_sample(input logic [AW-1:0] d);
        ADC_DATA = d;
        ADC_CLK  = 1'b1;
        tick();
        tick();
        ADC_CLK = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (BUSY && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (BUSY) begin
            failures++;
            $display("FAIL %s: BUSY still 1 after 50 cycles, expected 0", name);
        end
    endtask

    typedef struct packed {
        logic [3:0]        nsamp;
        logic [5:0][13:0]  smp;
        logic              fall_in_wnd;
        logic [1:0]        nexp;
        logic [2:0][31:0]  expw;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [31:0] w;

        // ---------------- table -------------------------------------------
        vecs[0].nsamp = 4'd4;
        vecs[0].smp   = {14'h0, 14'h0, 14'h44, 14'h33, 14'h22, 14'h11};
        vecs[0].fall_in_wnd = 1'b0;
        vecs[0].nexp  = 2'd2;
        vecs[0].expw  = {32'h0, 32'h00440033, 32'h00220011};

        vecs[1].nsamp = 4'd3;
        vecs[1].smp   = {14'h0, 14'h0, 14'h0, 14'h33, 14'h22, 14'h11};
        vecs[1].fall_in_wnd = 1'b0;
        vecs[1].nexp  = 2'd2;
        vecs[1].expw  = {32'h0, 32'h00000033, 32'h00220011};

        vecs[2].nsamp = 4'd5;
        vecs[2].smp   = {14'h0, 14'h0ABC, 14'h1234, 14'h2000, 14'h0001, 14'h3FFF};
        vecs[2].fall_in_wnd = 1'b0;
        vecs[2].nexp  = 2'd3;
        vecs[2].expw  = {32'h00000ABC, 32'h12342000, 32'h00013FFF};

        vecs[3].nsamp = 4'd1;
        vecs[3].smp   = {14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h55};
        vecs[3].fall_in_wnd = 1'b1;
        vecs[3].nexp  = 2'd1;
        vecs[3].expw  = {32'h0, 32'h0, 32'h00000055};

        // ---------------- reset state --------------------------------------
        repeat (3) tick();
        chk("rst_valid", 32'(OUT_VALID), 32'h0);
        chk("rst_data", OUT_DATA, 32'h0);
        chk("rst_echo", 32'(ECHO_CNT), 32'h0);
        chk("rst_samp", 32'(SAMPLE_CNT), 32'h0);
        chk("rst_ovf", 32'(OVERFLOW), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        RESET_N = 1'b1;
        tick();

        // ---------------- table-driven single-window sequences -------------
        for (int v = 0; v < 4; v++) begin
            got.delete();
            done_cnt  = 0;
            OUT_READY = 1'b1;
            FSMSTAT   = 1'b1;
            tick();
            tick();
            ACQ_WND = 1'b1;
            tick();
            for (int s = 0; s < int'(vecs[v].nsamp); s++) adc_sample(vecs[v].smp[s]);
            if (!vecs[v].fall_in_wnd) begin
                ACQ_WND = 1'b0;
                tick();
                tick();
            end
            FSMSTAT = 1'b0;
            wait_idle($sformatf("v%0d_idle", v));
            ACQ_WND = 1'b0;
            repeat (4) tick();
            chk($sformatf("v%0d_echo", v), 32'(ECHO_CNT), 32'd1);
            chk($sformatf("v%0d_samp", v), 32'(SAMPLE_CNT), 32'(vecs[v].nsamp));
            chk($sformatf("v%0d_nwords", v), 32'(got.size()), 32'(vecs[v].nexp));
            for (int k = 0; k < int'(vecs[v].nexp); k++) begin
                w = (k < got.size()) ? got[k] : 32'hDEADBEEF;
                chk($sformatf("v%0d_word%0d", v, k), w, vecs[v].expw[k]);
            end
            chk($sformatf("v%0d_done", v), 32'(done_cnt), 32'd1);
            chk($sformatf("v%0d_busy", v), 32'(BUSY), 32'h0);
            chk($sformatf("v%0d_ovf", v), 32'(OVERFLOW), 32'h0);
        end

        // ---------------- latency and FLUSH-with-window-open --------------
        OUT_READY = 1'b0;
        FSMSTAT   = 1'b1;
        tick();
        ACQ_WND = 1'b1;
        tick();
        adc_sample(14'h11);
        ADC_DATA = 14'h22;
        ADC_CLK  = 1'b1;
        chk("lat_before", 32'(OUT_VALID), 32'h0);
        tick();
        chk("lat_valid", 32'(OUT_VALID), 32'h1);
        chk("lat_data", OUT_DATA, 32'h00220011);
        ADC_CLK = 1'b0;
        tick();
        tick();
        adc_sample(14'h77);
        FSMSTAT = 1'b0;
        tick();
        chk("flush_done", 32'(DONE), 32'h1);
        chk("flush_busy", 32'(BUSY), 32'h1);
        chk("flush_head", OUT_DATA, 32'h00220011);
        tick();
        chk("flush_done_off", 32'(DONE), 32'h0);
        chk("flush_busy_off", 32'(BUSY), 32'h0);
        ACQ_WND   = 1'b0;
        OUT_READY = 1'b1;
        chk("flush_w0", OUT_DATA, 32'h00220011);
        tick();
        chk("flush_w1", OUT_DATA, 32'h00000077);
        tick();
        chk("flush_empty", 32'(OUT_VALID), 32'h0);

        // ---------------- overflow: 40 samples into a 16-word FIFO --------
        OUT_READY = 1'b0;
        FSMSTAT   = 1'b1;
        tick();
        ACQ_WND = 1'b1;
        tick();
        for (int s = 0; s < 40; s++) adc_sample(AW'(s + 1));
        chk("ovf_flag", 32'(OVERFLOW), 32'h1);
        chk("ovf_samp", 32'(SAMPLE_CNT), 32'd40);
        chk("ovf_echo", 32'(ECHO_CNT), 32'd1);
        ACQ_WND = 1'b0;
        tick();
        FSMSTAT = 1'b0;
        wait_idle("ovf_idle");
        got.delete();
        OUT_READY = 1'b1;
        repeat (20) tick();
        chk("ovf_nwords", 32'(got.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            w = (k < got.size()) ? got[k] : 32'hDEADBEEF;
            chk($sformatf("ovf_word%0d", k), w, {16'(2 * k + 2), 16'(2 * k + 1)});
        end
        chk("ovf_drained", 32'(OUT_VALID), 32'h0);

        // ---------------- three echoes, counter clearing ------------------
        chk("pre_ovf_sticky", 32'(OVERFLOW), 32'h1);
        got.delete();
        done_cnt = 0;
        FSMSTAT  = 1'b1;
        tick();
        chk("clr_ovf", 32'(OVERFLOW), 32'h0);
        chk("clr_echo", 32'(ECHO_CNT), 32'h0);
        chk("clr_samp", 32'(SAMPLE_CNT), 32'h0);
        for (int e = 1; e <= 3; e++) begin
            ACQ_WND = 1'b1;
            tick();
            adc_sample(AW'(e * 256 + 1));
            adc_sample(AW'(e * 256 + 2));
            ACQ_WND = 1'b0;
            tick();
            tick();
        end
        FSMSTAT = 1'b0;
        wait_idle("echo3_idle");
        repeat (4) tick();
        chk("echo3_echo", 32'(ECHO_CNT), 32'd3);
        chk("echo3_samp", 32'(SAMPLE_CNT), 32'd6);
        chk("echo3_nwords", 32'(got.size()), 32'd3);
        chk("echo3_w0", (got.size() > 0) ? got[0] : 32'hDEADBEEF, 32'h01020101);
        chk("echo3_w1", (got.size() > 1) ? got[1] : 32'hDEADBEEF, 32'h02020201);
        chk("echo3_w2", (got.size() > 2) ? got[2] : 32'hDEADBEEF, 32'h03020301);

        // ---------------- window activity without FSMSTAT ------------------
        for (int t = 0; t < 3; t++) begin
            ACQ_WND = 1'b1;
            adc_sample(14'h3AB);
            ACQ_WND = 1'b0;
            tick();
        end
        repeat (3) tick();
        chk("idle_nwords", 32'(got.size()), 32'd3);
        chk("idle_echo", 32'(ECHO_CNT), 32'd3);
        chk("idle_samp", 32'(SAMPLE_CNT), 32'd6);
        chk("idle_busy", 32'(BUSY), 32'h0);

        FSMSTAT = 1'b1;
        tick();
        chk("rerise_echo", 32'(ECHO_CNT), 32'h0);
        chk("rerise_samp", 32'(SAMPLE_CNT), 32'h0);
        FSMSTAT = 1'b0;
        wait_idle("rerise_idle");

        // ---------------- reset mid-CAPTURE with 5 words buffered ---------
        OUT_READY = 1'b0;
        FSMSTAT   = 1'b1;
        tick();
        ACQ_WND = 1'b1;
        tick();
        for (int s = 0; s < 10; s++) adc_sample(AW'(s + 16'h100));
        chk("mid_valid", 32'(OUT_VALID), 32'h1);
        chk("mid_samp", 32'(SAMPLE_CNT), 32'd10);
        RESET_N = 1'b0;
        #1;
        chk("arst_valid", 32'(OUT_VALID), 32'h0);
        chk("arst_data", OUT_DATA, 32'h0);
        chk("arst_echo", 32'(ECHO_CNT), 32'h0);
        chk("arst_samp", 32'(SAMPLE_CNT), 32'h0);
        chk("arst_busy", 32'(BUSY), 32'h0);
        FSMSTAT = 1'b0;
        ACQ_WND = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", 32'(OUT_VALID), 32'h0);
        chk("post_rst_busy", 32'(BUSY), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
